// File: rtl/signed_mul_seq.sv
// Sequential signed/unsigned multiplier: magnitude conversion, WIDTH-cycle
// shift-add, optional re-negation of the 2*WIDTH product.

module twos #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);
    // The most-negative value maps to itself; callers read it as unsigned.
    assign y = ~x + {{(W-1){1'b0}}, 1'b1};
endmodule

module signed_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        st_idle,
        st_prep,
        st_mul,
        st_fix,
        st_done
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0]   a_q, b_q;
    logic               sgn_q;
    logic               neg_res;
    logic [WIDTH-1:0]   ma, mb;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   a_neg, b_neg;
    logic [2*WIDTH-1:0] acc_neg;
    logic [WIDTH:0]     sum;

    twos #(.W(WIDTH))   u_twos_a   (.x(a_q), .y(a_neg));
    twos #(.W(WIDTH))   u_twos_b   (.x(b_q), .y(b_neg));
    twos #(.W(2*WIDTH)) u_twos_acc (.x(acc), .y(acc_neg));

    // High half plus the gated multiplicand; the extra bit keeps the carry.
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mb[0] ? ma : {WIDTH{1'b0}})};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= st_idle;
        else     state <= state_nx;
    end

    // NOTE: next-state is defaulted before the case so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            st_idle: if (start) state_nx = st_prep;
            st_prep: state_nx = st_mul;
            st_mul:  if (cnt == CW'(WIDTH - 1)) state_nx = st_fix;
            st_fix:  state_nx = st_done;
            st_done: state_nx = st_idle;
            default: state_nx = st_idle;
        endcase
    end

    // Outputs decode directly from the state flops: no input-to-output path.
    assign busy = (state != st_idle);
    assign done = (state == st_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            neg_res <= 1'b0;
            ma      <= '0;
            mb      <= '0;
            acc     <= '0;
            cnt     <= '0;
            p       <= '0;
        end else begin
            case (state)
                st_idle: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        sgn_q <= sgn;
                    end
                end
                st_prep: begin
                    neg_res <= sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    ma      <= (sgn_q & a_q[WIDTH-1]) ? a_neg : a_q;
                    mb      <= (sgn_q & b_q[WIDTH-1]) ? b_neg : b_q;
                    acc     <= '0;
                    cnt     <= '0;
                end
                st_mul: begin
                    acc <= {sum, acc[WIDTH-1:1]};
                    mb  <= mb >> 1;
                    cnt <= cnt + CW'(1);
                end
                st_fix: begin
                    p <= neg_res ? acc_neg : acc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_signed_mul_seq.sv
// Self-checking bench for signed_mul_seq (WIDTH=8): directed corners,
// handshake/throughput, mid-operation reset and randomized operands.

module tb_signed_mul_seq;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           sgn;
    logic [W-1:0]   a, b;
    logic           busy, done;
    logic [2*W-1:0] p;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_times[$];

    signed_mul_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sgn   (sgn),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            done_times.push_back(cyc);
        end
    end

    // Reference: plain integer multiply of the operands as the host sees them.
    function automatic logic [2*W-1:0] ref_mul(input bit s, input logic [W-1:0] x, input logic [W-1:0] y);
        int xi, yi, r;
        xi = s ? int'($signed(x)) : int'(x);
        yi = s ? int'($signed(y)) : int'(y);
        r  = xi * yi;
        return r[2*W-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) check({tag, "_idle_timeout"}, busy, 0);
    endtask

    // One full operation with latency checks; inputs are scrambled while busy.
    task automatic run_op(input bit s, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        logic [2*W-1:0] exp;
        bit early;
        exp = ref_mul(s, x, y);
        wait_idle(tag);
        sgn = s; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sgn = ~s; a = 8'($urandom); b = 8'($urandom);
        check({tag, "_busy_after_accept"}, busy, 1);
        early = 0;
        repeat (W + 1) begin
            @(posedge clk); #1;
            if (done) early = 1;
        end
        check({tag, "_no_early_done"}, early, 0);
        @(posedge clk); #1;
        check({tag, "_done"}, done, 1);
        check({tag, "_p"}, p, exp);
        @(posedge clk); #1;
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_p_hold"}, p, exp);
    endtask

    initial begin
        int d0;
        logic [2*W-1:0] exp_hs;

        rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_p", p, 0);
        rst = 1'b0;

        // Directed corners
        run_op(1'b1, 8'd3,  8'd5,  "pos");
        run_op(1'b1, 8'hFD, 8'd5,  "neg_a");
        run_op(1'b1, 8'd5,  8'hFD, "neg_b");
        run_op(1'b1, 8'h80, 8'h80, "minmin");
        run_op(1'b1, 8'h80, 8'h7F, "minmax");
        run_op(1'b0, 8'hFF, 8'hFF, "unsigned_max");
        run_op(1'b1, 8'h00, 8'hFF, "neg_zero");
        check("const_pos", ref_mul(1'b1, 8'd3, 8'd5), 16'h000F);

        // Start pulses during every busy cycle are ignored
        wait_idle("hs");
        d0 = done_cnt;
        sgn = 1'b1; a = 8'hF9; b = 8'd11;
        exp_hs = ref_mul(1'b1, 8'hF9, 8'd11);
        start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            sgn = 1'($urandom); a = 8'($urandom); b = 8'($urandom); start = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("hs_done_count", done_cnt - d0, 1);
        check("hs_p_first_operands", p, exp_hs);
        check("hs_idle", busy, 0);

        // Start held high: one result every WIDTH+4 cycles
        wait_idle("hold");
        d0 = done_times.size();
        sgn = 1'b1; a = 8'h80; b = 8'h7F; start = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("hold_done_count", done_times.size() - d0, 3);
        if (done_times.size() - d0 == 3) begin
            check("hold_spacing_1", done_times[d0 + 1] - done_times[d0], W + 4);
            check("hold_spacing_2", done_times[d0 + 2] - done_times[d0 + 1], W + 4);
        end
        check("hold_p", p, 16'hC080);

        // Reset four cycles into the multiply phase
        wait_idle("rst");
        d0 = done_cnt;
        sgn = 1'b0; a = 8'd200; b = 8'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("rst_async_busy", busy, 0);
        check("rst_async_done", done, 0);
        check("rst_async_p", p, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_p_still_zero", p, 0);
        run_op(1'b0, 8'd7, 8'd9, "after_rst");

        // Randomized operands against the reference
        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom), 8'($urandom), 8'($urandom), $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/signed_mul_seq.md
# signed_mul_seq

Sequential signed/unsigned multiplier controller. It sequences the team's `twos` negation datapath around an unsigned shift-add core. Signed operands are converted to magnitudes with `twos`, multiplied over WIDTH cycles, and the product is conditionally re-negated through a 2*WIDTH `twos` instance. It sits between the host register interface and the multiplier datapath, and owns all sequencing and handshake.

## Interface
Parameters:
- `WIDTH`, default 8: operand width in bits; product is 2*WIDTH bits; WIDTH >= 2.

Ports:
- `clk`  input  1: single clock, rising edge.
- `rst`  input  1: reset, asynchronous, active-high.
- `start`  input  1: request; sampled only in IDLE.
- `sgn`  input  1: 1 = operands are two's complement signed, 0 = unsigned; sampled with `start`.
- `a`  input  WIDTH: multiplicand; sampled with `start`.
- `b`  input  WIDTH: multiplier; sampled with `start`.
- `busy`  output  1: high in every state except IDLE.
- `done`  output  1: one-cycle pulse; `p` is valid in that cycle.
- `p`  output  2*WIDTH: product; holds its value until the next accepted `start` or reset.

## Operation
- States: IDLE, PREP, MUL, FIX, DONE.
- **IDLE**
  - `start`=1 at a rising edge latches `a`, `b` and `sgn`, and moves to PREP.
  - `start`=0 stays in IDLE.
- **PREP** (1 cycle)
  - `neg_res` = `sgn` & (a[MSB] ^ b[MSB]).
  - Magnitude registers load `twos(a)` if `sgn` & a[MSB], else `a`. Same rule for `b`.
  - Accumulator clears to 0, bit counter clears to 0. Next state is MUL.
- **MUL** (exactly WIDTH cycles)
  - Each cycle: if multiplier LSB = 1, the accumulator high half adds the multiplicand magnitude, carry kept in a (WIDTH+1)-bit sum.
  - Then {carry, acc} shifts right by 1 and the multiplier shifts right by 1. The counter increments.
  - Leaves to FIX when the counter reaches WIDTH-1.
- **FIX** (1 cycle)
  - `p` loads `twos(acc)` (2*WIDTH-bit instance) if `neg_res`, else `acc`. Next state is DONE.
- **DONE** (1 cycle)
  - `done`=1. Next state is IDLE.
- Arithmetic rules:
  - Magnitudes are treated as unsigned WIDTH bits. `twos` of the most-negative value returns itself, which is read as unsigned 2^(WIDTH-1). This is correct: (-2^(W-1))*(-2^(W-1)) = 2^(2W-2) fits in 2*WIDTH.
  - A negative-zero result (e.g. 0 * -1) yields `twos(0)` = 0.
  - Overflow is impossible. The full 2*WIDTH product is always returned.
- `start` while `busy`=1 is ignored, with no queueing. The inputs latched at acceptance are unaffected by later changes on `a`, `b` or `sgn`.
- `start` held high through DONE is accepted again in the IDLE cycle that follows. Back-to-back operations therefore have one IDLE cycle between them.

## Timing
- Reset (async assert, any state):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `p`=0.
  - Accumulator, magnitudes and counter are cleared.
  - Reset mid-operation abandons the operation with no `done` pulse.
- Release is synchronous to `clk`. The first `start` can be accepted at the first rising edge with `rst`=0.
- Latency: if `start` is sampled at edge k, then:
  - `busy`=1 from just after edge k.
  - `p` is updated at edge k+WIDTH+2.
  - `done`=1 in the cycle following edge k+WIDTH+2.
  - `busy`=0 after edge k+WIDTH+3.
- Total occupancy is WIDTH+3 cycles per operation; throughput is one result per WIDTH+4 cycles when `start` is held high.
- `done` and `busy` are registered outputs (state decode off flops), so there is no combinational path from inputs to outputs.

## Test plan
All scenarios use WIDTH=8.
- Signed positive: `sgn`=1, a=3, b=5 -> `done` 11 cycles after the accept edge, p=0x000F.
- Signed mixed sign: `sgn`=1, a=0xFD (-3), b=5 -> p=0xFFF1 (-15). Also a=5, b=0xFD -> p=0xFFF1.
- Most-negative corner: `sgn`=1, a=b=0x80 -> p=0x4000. Also a=0x80, b=0x7F -> p=0xC080 (-16256).
- Unsigned and zero: `sgn`=0, a=b=0xFF -> p=0xFE01. Also `sgn`=1, a=0x00, b=0xFF -> p=0x0000.
- Handshake: pulse `start` again on each of the 10 busy cycles with different operands -> exactly one `done`, and the result is that of the first operands. With `start` held high for 30 cycles -> a `done` pulse every 12 cycles.
- Reset mid-operation: assert `rst` 4 cycles into MUL -> `busy`, `done` and `p` go to 0 immediately with no `done` pulse. A new operation a=7, b=9 after release -> p=0x003F.
